ls_ou: RTL

Parametrised load/store operation unit for the RCA reconfigurable datapath, and the general successor to the single-width load unit. It is configured per instance for access width, load or store mode, and a constant address offset. It tracks outstanding loads with a credit counter and buffers returned load data in an in-order result FIFO, so downstream consumers may stall. It sits between two RCA operand channels and the LSQ request/response interface.

---
 rtl/ls_ou.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ls_ou.sv
// ls_ou - parametrised load/store operation unit for the RCA datapath.
//
// Takes a base address (and, in store mode, store data) from two RCA operand
// channels. It raises a request to the LSQ with address = base + OFFSET. In load mode
// the unit keeps a credit count of outstanding loads. Returned load data is
// buffered in an in-order FIFO, so the downstream consumer may stall without
// losing responses.
//
// Parameters:
//   XLEN      datapath width
//   FN3       access width/sign code forwarded to the LSQ (constant per instance)
//   IS_STORE  0 = load unit, 1 = store unit
//   OFFSET    constant added to the base address (wraps modulo 2^XLEN)
//   DEPTH     max loads in flight + buffered; power of two, 2..16
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   data_in1/data_valid_in1          base address operand
//   data_in2/data_valid_in2          store data operand (store mode only)
//   data_in_ack1/data_in_ack2        operand consumed this cycle
//   uses_data_in1/uses_data_in2      static operand usage flags
//   data_out/data_valid_out          head of the result FIFO
//   data_out_ack                     consumer takes data_out this cycle
//   addr, data, fn3, load, store     LSQ request fields
//   new_request                      LSQ request strobe
//   lsq_full                         LSQ cannot accept a request
//   load_data/load_complete          in-order LSQ load response

module ls_ou #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [2:0]          FN3      = 3'b001,
    parameter bit                  IS_STORE = 1'b0,
    parameter logic [XLEN-1:0]     OFFSET   = '0,
    parameter int unsigned         DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [XLEN-1:0] data_in1,
    input  logic            data_valid_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,

    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    input  logic            data_out_ack,

    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Credit and FIFO state
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] mem [DEPTH];

    // Sticky flag: a completion arrived with no load outstanding.
    logic            err_unexp;

    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            issue;
    logic            load_issue;
    logic            push;
    logic            pop;
    logic            unexp_cpl;

    // ------------------------------------------------------------------
    // Static request fields
    // ------------------------------------------------------------------
    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = IS_STORE;
    assign fn3           = FN3;
    assign load          = !IS_STORE;
    assign store         = IS_STORE;

    assign addr = data_in1 + OFFSET;
    assign data = IS_STORE ? data_in2 : '0;

    // ------------------------------------------------------------------
    // Issue logic. The credit check only looks at registered counters, so a
    // pop in this cycle frees its slot for the next cycle, not this one.
    // ------------------------------------------------------------------
    assign occupancy = {1'b0, in_flight} + {1'b0, count};
    assign credit_ok = (occupancy < DEPTH_W);

    always_comb begin
        issue = 1'b0;
        if (IS_STORE) begin
            issue = data_valid_in1 && data_valid_in2 && !lsq_full;
        end else begin
            issue = data_valid_in1 && !lsq_full && credit_ok;
        end
    end

    assign new_request  = issue;
    assign data_in_ack1 = issue;
    assign data_in_ack2 = IS_STORE ? issue : 1'b0;

    assign load_issue = !IS_STORE && issue;

    // ------------------------------------------------------------------
    // Completion handling. Store units ignore responses entirely.
    // ------------------------------------------------------------------
    assign push      = !IS_STORE && load_complete && (in_flight != '0);
    assign unexp_cpl = !IS_STORE && load_complete && (in_flight == '0);

    assign data_valid_out = (count != '0);
    assign pop            = data_valid_out && data_out_ack;
    assign data_out       = data_valid_out ? mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Outstanding-load counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({load_issue, push})
                2'b10:   in_flight <= in_flight + ONE_C;
                2'b01:   in_flight <= in_flight - ONE_C;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO control. Power-of-two depth lets the pointers wrap freely.
    // No overflow guard is needed: credits bound in_flight + count by DEPTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; data_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Protocol error flag, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexp <= 1'b0;
        end else if (unexp_cpl) begin
            err_unexp <= 1'b1;
        end
    end

endmodule
